timer_arbiter: RTL and testbench
================================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, bit width of the shared interval counter and of each duration input.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: req  input  2  per-requester interval request, level; bit i belongs to requester i.
REQ-005 Port: dur0  input  WIDTH  requester 0 interval length; sampled only at grant.
REQ-006 Port: dur1  input  WIDTH  requester 1 interval length; sampled only at grant.
REQ-007 Port: gnt  output  2  one-hot grant, registered; high for the whole interval.
REQ-008 Port: done  output  2  one-cycle completion pulse to the owning requester, registered.
REQ-009 Port: busy  output  1  high while state is RUN.
REQ-010 Port: count  output  WIDTH  current value of the shared counter.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-012 In IDLE with req nonzero, the next edge SHALL: enter RUN, set gnt to the winner's one-hot value, load count=0, latch the winner's duration into dur_q, and record the winner as owner.
REQ-013 Arbitration SHALL be round-robin: a single request always wins; with both bits set, the requester not granted most recently wins.
REQ-014 In RUN with req[owner]=1 and count!=dur_q, count SHALL increment by 1 per cycle.
REQ-015 In RUN with req[owner]=1 and count==dur_q, the next edge SHALL: enter IDLE, clear gnt and count, and pulse done[owner] high for exactly one cycle.
REQ-016 In RUN with req[owner]=0, the next edge SHALL abort: enter IDLE, clear gnt and count, no done pulse; the round-robin pointer still advances.
REQ-017 Latency: req seen in IDLE at cycle N gives gnt at N+1, count 0..d over cycles N+1..N+1+d, and done high with gnt low at N+2+d.
REQ-018 dur=0 SHALL give a one-cycle grant, with done at N+2.
REQ-019 Each grant SHALL be followed by at least one IDLE cycle; a still-pending request is granted no earlier than N+3+d.
REQ-020 gnt and done SHALL never be high in the same cycle, and gnt SHALL never have more than one bit set.
REQ-021 Changes on dur0/dur1 during RUN SHALL have no effect on the current interval.
REQ-022 count SHALL never exceed dur_q, so no wrap-around occurs; dur=2^WIDTH-1 SHALL run the full range.
REQ-023 Requests arriving during RUN from the non-owner SHALL be held off, not lost, while the level stays asserted.

Reset
REQ-024 rst=1 at an edge SHALL force state IDLE, gnt=0, done=0, busy=0, count=0, dur_q=0, and set the pointer so requester 0 wins the first tie.
REQ-025 rst asserted mid-interval SHALL abort the interval with no done pulse; rst SHALL take priority over every other event.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef (IDLE, RUN) and the default WIDTH constant.
REQ-027 The counter SHALL be a sub-module, sync_counter, with synchronous clear, enable and a WIDTH-bit output; the FSM drives clear and enable.
REQ-028 The target implementation size is 120-400 lines of RTL.

Verification
REQ-029 Scenario: rst, then req=01 with dur0=3 at N -> gnt=01 over N+1..N+4, count 0,1,2,3, done=01 at N+5 only.
REQ-030 Scenario: req=11 held, dur0=2, dur1=1, after reset -> requester 0 is granted first; done=01; one IDLE cycle; then gnt=10; done=10; then gnt=01 again.
REQ-031 Scenario: req=10, dur1=0 -> gnt=10 for one cycle, then done=10 the next cycle.
REQ-032 Scenario: req=01, dur0=5; req[0] dropped at count=2 -> gnt=00 and IDLE next cycle, no done pulse; a pending req[1] is granted the following cycle.
REQ-033 Scenario: rst pulsed at count=1 of a dur=4 interval -> all outputs 0 next cycle and no done; a tie after release goes to requester 0.
REQ-034 Scenario: dur0=15 with WIDTH=4 -> count reaches 15 without wrapping, done at N+17; dur0 changed mid-run has no effect.

Source files
------------

// File: rtl/timer_arbiter_pkg.sv
// Shared types and defaults for the two-requester interval timer arbiter.
package timer_arbiter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/timer_arbiter_sync_counter.sv
// Up-counter with synchronous reset, synchronous clear and count enable.
module sync_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting one requester at a time a timed interval on a
// shared counter; signals completion with a one-cycle done pulse.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] dur0,
    input  logic [WIDTH-1:0] dur1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    state_t           state_q, state_d;
    logic [1:0]       gnt_d, done_d;
    logic [WIDTH-1:0] dur_q, dur_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             winner_c;
    logic             cnt_clr_c, cnt_en_c;

    sync_counter #(.WIDTH(WIDTH)) u_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_c),
        .en  (cnt_en_c),
        .q   (count)
    );

    // last_q holds the most recently granted requester; a tie goes to the other one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt     <= 2'b00;
            done    <= 2'b00;
            busy    <= 1'b0;
            dur_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            done    <= done_d;
            busy    <= (state_d == RUN);
            dur_q   <= dur_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        dur_d     = dur_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_clr_c = 1'b0;
        cnt_en_c  = 1'b0;
        winner_c  = (req == 2'b11) ? ~last_q : req[1];

        case (state_q)
            IDLE: begin
                cnt_clr_c = 1'b1;
                if (req != 2'b00) begin
                    state_d = RUN;
                    gnt_d   = winner_c ? 2'b10 : 2'b01;
                    dur_d   = winner_c ? dur1 : dur0;
                    owner_d = winner_c;
                    last_d  = winner_c;
                end
            end
            RUN: begin
                if (!req[owner_q]) begin
                    state_d   = IDLE;
                    cnt_clr_c = 1'b1;
                end else if (count == dur_q) begin
                    state_d   = IDLE;
                    cnt_clr_c = 1'b1;
                    done_d    = owner_q ? 2'b10 : 2'b01;
                end else begin
                    gnt_d    = gnt;
                    cnt_en_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: interval-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_timer_arbiter;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [WIDTH-1:0] dur0, dur1;
    logic [1:0]       gnt, done;
    logic             busy;
    logic [WIDTH-1:0] count;

    int checks = 0;
    int errors = 0;

    timer_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .dur0  (dur0),
        .dur1  (dur1),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    // Reference model: an interval is (owner, start cycle, length); outputs follow
    // from elapsed time since start.
    int         cyc = 0;
    bit         m_valid = 0;
    bit         m_active = 0;
    int         m_owner = 0;
    int         m_last = 1;
    int         m_start = 0;
    int         m_len = 0;
    logic [1:0] m_done = 2'b00;

    always @(posedge clk) begin
        m_done = 2'b00;
        if (rst) begin
            m_valid  = 1;
            m_active = 0;
            m_last   = 1;
        end else if (m_active) begin
            if (!req[m_owner]) begin
                m_active = 0;
            end else if (cyc - m_start == m_len) begin
                m_active = 0;
                m_done[m_owner] = 1'b1;
            end
        end else if (req != 2'b00) begin
            if (req == 2'b11) m_owner = 1 - m_last;
            else              m_owner = req[1] ? 1 : 0;
            m_last   = m_owner;
            m_len    = (m_owner == 1) ? int'(dur1) : int'(dur0);
            m_start  = cyc + 1;
            m_active = 1;
        end
        cyc++;
    end

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("model_gnt", int'(gnt), m_active ? (1 << m_owner) : 0);
            cmp("model_done", int'(done), int'(m_done));
            cmp("model_busy", int'(busy), m_active ? 1 : 0);
            cmp("model_count", int'(count), m_active ? (cyc - m_start) : 0);
            cmp("gnt_done_overlap", int'(gnt & done), 0);
            cmp("gnt_onehot", int'($onehot0(gnt)), 1);
        end
    end

    task automatic step(input string name, input logic [1:0] egnt,
                        input logic [1:0] edone, input int ecount);
        @(negedge clk);
        cmp({name, "_gnt"}, int'(gnt), int'(egnt));
        cmp({name, "_done"}, int'(done), int'(edone));
        cmp({name, "_count"}, int'(count), ecount);
        cmp({name, "_busy"}, int'(busy), (egnt != 2'b00) ? 1 : 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        cmp("rst_gnt", int'(gnt), 0);
        cmp("rst_done", int'(done), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_count", int'(count), 0);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 2'b00;
        dur0 = '0;
        dur1 = '0;

        // Single request, dur0=3
        do_reset();
        req = 2'b01; dur0 = 4'd3;
        for (int k = 0; k < 4; k++) step("s1_run", 2'b01, 2'b00, k);
        step("s1_done", 2'b00, 2'b01, 0);
        req = 2'b00;
        step("s1_after", 2'b00, 2'b00, 0);

        // Tie held: 0 first, then 1, then 0 again
        do_reset();
        req = 2'b11; dur0 = 4'd2; dur1 = 4'd1;
        step("s2_g0a", 2'b01, 2'b00, 0);
        step("s2_g0b", 2'b01, 2'b00, 1);
        step("s2_g0c", 2'b01, 2'b00, 2);
        step("s2_d0", 2'b00, 2'b01, 0);
        step("s2_g1a", 2'b10, 2'b00, 0);
        step("s2_g1b", 2'b10, 2'b00, 1);
        step("s2_d1", 2'b00, 2'b10, 0);
        step("s2_g0again", 2'b01, 2'b00, 0);
        req = 2'b00;
        step("s2_abort", 2'b00, 2'b00, 0);

        // Zero duration on requester 1
        req = 2'b10; dur1 = 4'd0;
        step("s3_g", 2'b10, 2'b00, 0);
        step("s3_d", 2'b00, 2'b10, 0);
        req = 2'b00;
        step("s3_idle", 2'b00, 2'b00, 0);

        // Abort at count=2 with req[1] pending
        req = 2'b01; dur0 = 4'd5;
        step("s4_c0", 2'b01, 2'b00, 0);
        req = 2'b11;
        step("s4_c1", 2'b01, 2'b00, 1);
        step("s4_c2", 2'b01, 2'b00, 2);
        req = 2'b10;
        step("s4_abort", 2'b00, 2'b00, 0);
        step("s4_g1", 2'b10, 2'b00, 0);
        req = 2'b00;
        step("s4_idle", 2'b00, 2'b00, 0);

        // Reset mid-interval, then a tie goes to requester 0
        do_reset();
        req = 2'b01; dur0 = 4'd4;
        step("s5_c0", 2'b01, 2'b00, 0);
        step("s5_c1", 2'b01, 2'b00, 1);
        rst = 1'b1;
        step("s5_rst", 2'b00, 2'b00, 0);
        rst = 1'b0; req = 2'b11;
        step("s5_tie", 2'b01, 2'b00, 0);
        req = 2'b00;
        step("s5_idle", 2'b00, 2'b00, 0);

        // Full range, dur0 changed mid-run
        do_reset();
        req = 2'b01; dur0 = 4'd15;
        for (int k = 0; k < 16; k++) begin
            step("s6_run", 2'b01, 2'b00, k);
            if (k == 2) dur0 = 4'd2;
        end
        step("s6_done", 2'b00, 2'b01, 0);
        req = 2'b00;
        step("s6_idle", 2'b00, 2'b00, 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
